// File: rtl/any1_tlb_walker.sv
// Hardware page-table walker: on a TLB miss edge, read one 64-bit PTE and write it into a 4-way TLB.
// Latency: miss edge -> cyc_o next cycle; ack -> wrtlb_o next cycle -> done_o the cycle after.
// Backpressure: the bus stalls the walk until ack/err or timeout; one extra miss is held pending while busy.
//
// Ports: clk_i/rst_i (sync, active-high); tlbmiss_i, miss_adr_i, asid_i, ptbr_i walk inputs;
//        cyc_o/stb_o/adr_o/ack_i/err_i/dat_i read-only bus; wrtlb_o/tlbadr_o/tlbdat_o TLB write port;
//        busy_o, done_o, fault_o status.
module any1_tlb_walker #(
    parameter int AWID = 32,
    parameter int TMO  = 255
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            tlbmiss_i,
    input  logic [AWID-1:0] miss_adr_i,
    input  logic [7:0]      asid_i,
    input  logic [AWID-1:0] ptbr_i,
    output logic            cyc_o,
    output logic            stb_o,
    output logic [AWID-1:0] adr_o,
    input  logic            ack_i,
    input  logic            err_i,
    input  logic [63:0]     dat_i,
    output logic            wrtlb_o,
    output logic [11:0]     tlbadr_o,
    output logic [63:0]     tlbdat_o,
    output logic            busy_o,
    output logic            done_o,
    output logic            fault_o
);

    localparam int TW = $clog2(TMO + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO - 1);

    typedef enum logic [2:0] {ST_IDLE, ST_READ, ST_WRITE, ST_DONE, ST_FAULT} state_t;

    state_t           state_q, state_d;
    logic             miss_prev_q;
    logic             pend_q, pend_d;
    logic [AWID-15:0] vpn_q, vpn_d;          // miss_adr[AWID-1:14]
    logic [7:0]       asid_q, asid_d;
    logic [1:0]       way_q, way_d;
    logic [TW-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic             cyc_q, cyc_d;
    logic [AWID-1:0]  adr_q, adr_d;
    logic             wrtlb_q, wrtlb_d;
    logic [11:0]      tlbadr_q, tlbadr_d;
    logic [63:0]      tlbdat_q, tlbdat_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             fault_q, fault_d;

    logic             req;
    logic [AWID-1:0]  pte_off;
    logic [7:0]       vpn_hi8;
    logic             unused_bits;

    assign req         = tlbmiss_i & ~miss_prev_q;
    // Each PTE is 8 bytes, one per 16 KiB page.
    assign pte_off     = AWID'({miss_adr_i[AWID-1:14], 3'b000});
    assign vpn_hi8     = 8'(vpn_q[AWID-15:10]);
    assign unused_bits = ^{miss_adr_i[13:0], dat_i[63:56], dat_i[54:53], dat_i[39:32]};

    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        vpn_d     = vpn_q;
        asid_d    = asid_q;
        way_d     = way_q;
        tmo_cnt_d = tmo_cnt_q;
        cyc_d     = 1'b0;
        adr_d     = '0;
        wrtlb_d   = 1'b0;
        tlbadr_d  = tlbadr_q;
        tlbdat_d  = tlbdat_q;
        done_d    = 1'b0;
        fault_d   = 1'b0;

        // Misses seen mid-walk collapse into a single pending walk.
        if (req && state_q != ST_IDLE) pend_d = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (req || pend_q) begin
                    state_d   = ST_READ;
                    pend_d    = 1'b0;
                    vpn_d     = miss_adr_i[AWID-1:14];
                    asid_d    = asid_i;
                    tmo_cnt_d = '0;
                    cyc_d     = 1'b1;
                    adr_d     = ptbr_i + pte_off;
                end
            end
            ST_READ: begin
                if (err_i) begin
                    state_d = ST_FAULT;
                    fault_d = 1'b1;
                end else if (ack_i && dat_i[47]) begin
                    state_d  = ST_WRITE;
                    wrtlb_d  = 1'b1;
                    tlbadr_d = {way_q, vpn_q[9:0]};
                    // Dirty/accessed are cleared so the TLB re-traps on first use.
                    tlbdat_d = {asid_q, dat_i[55], 2'b00, dat_i[52:40], vpn_hi8, dat_i[31:0]};
                end else if (ack_i) begin
                    state_d = ST_FAULT;
                    fault_d = 1'b1;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    state_d = ST_FAULT;
                    fault_d = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
                    cyc_d     = 1'b1;
                    adr_d     = adr_q;
                end
            end
            ST_WRITE: begin
                state_d = ST_DONE;
                done_d  = 1'b1;
                way_d   = way_q + 2'd1;
            end
            ST_DONE:  state_d = ST_IDLE;
            ST_FAULT: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            // A level held through reset must not look like a fresh miss afterwards.
            miss_prev_q <= tlbmiss_i;
            pend_q      <= 1'b0;
            vpn_q       <= '0;
            asid_q      <= '0;
            way_q       <= '0;
            tmo_cnt_q   <= '0;
            cyc_q       <= 1'b0;
            adr_q       <= '0;
            wrtlb_q     <= 1'b0;
            tlbadr_q    <= '0;
            tlbdat_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            miss_prev_q <= tlbmiss_i;
            pend_q      <= pend_d;
            vpn_q       <= vpn_d;
            asid_q      <= asid_d;
            way_q       <= way_d;
            tmo_cnt_q   <= tmo_cnt_d;
            cyc_q       <= cyc_d;
            adr_q       <= adr_d;
            wrtlb_q     <= wrtlb_d;
            tlbadr_q    <= tlbadr_d;
            tlbdat_q    <= tlbdat_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            fault_q     <= fault_d;
        end
    end

    assign cyc_o    = cyc_q;
    assign stb_o    = cyc_q;
    assign adr_o    = adr_q;
    assign wrtlb_o  = wrtlb_q;
    assign tlbadr_o = tlbadr_q;
    assign tlbdat_o = tlbdat_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign fault_o  = fault_q;

endmodule

// File: tb/tb_any1_tlb_walker.sv
// Testbench for any1_tlb_walker: directed scenarios plus randomized walks against a reference model.
// Latency: checks miss->cyc (1), ack->wrtlb (1), ack->done (2), timeout length.
// Backpressure: bus ack delay is varied; pending-miss merging is exercised.
module tb_any1_tlb_walker;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        tlbmiss_i = 1'b0;
    logic [31:0] miss_adr_i = '0;
    logic [7:0]  asid_i = '0;
    logic [31:0] ptbr_i = '0;
    logic        cyc_o, stb_o;
    logic [31:0] adr_o;
    logic        ack_i = 1'b0;
    logic        err_i = 1'b0;
    logic [63:0] dat_i = '0;
    logic        wrtlb_o;
    logic [11:0] tlbadr_o;
    logic [63:0] tlbdat_o;
    logic        busy_o, done_o, fault_o;

    int total = 0;
    int bad = 0;
    int wr_cnt = 0;
    int ref_way = 0;

    always #5 clk = ~clk;

    any1_tlb_walker #(.AWID(32), .TMO(255)) dut (
        .clk_i(clk), .rst_i(rst_i), .tlbmiss_i(tlbmiss_i), .miss_adr_i(miss_adr_i),
        .asid_i(asid_i), .ptbr_i(ptbr_i), .cyc_o(cyc_o), .stb_o(stb_o), .adr_o(adr_o),
        .ack_i(ack_i), .err_i(err_i), .dat_i(dat_i), .wrtlb_o(wrtlb_o), .tlbadr_o(tlbadr_o),
        .tlbdat_o(tlbdat_o), .busy_o(busy_o), .done_o(done_o), .fault_o(fault_o)
    );

    always @(posedge clk) if (wrtlb_o === 1'b1) wr_cnt++;

    // Reference model: byte address of the PTE, TLB entry word and TLB slot.
    function automatic logic [31:0] m_adr(input logic [31:0] ptbr, input logic [31:0] miss);
        return ptbr + ((miss >> 14) << 3);
    endfunction

    function automatic logic [63:0] m_dat(input logic [7:0] asid, input logic [31:0] miss,
                                          input logic [63:0] pte);
        logic [63:0] a, m;
        a = {56'd0, asid};
        m = {32'd0, miss};
        return (a << 56) | (pte & 64'h009F_FF00_FFFF_FFFF) | ((m >> 24) << 32);
    endfunction

    function automatic logic [11:0] m_tadr(input int way, input logic [31:0] miss);
        return 12'((way % 4) * 1024 + ((miss >> 14) % 1024));
    endfunction

    task automatic run_walk(input logic [31:0] miss, input logic [7:0] asid, input logic [31:0] ptbr,
                            input logic [63:0] pte, input int dly, input bit err,
                            output int cyc_lat, output logic [31:0] adr_seen, output logic wr1,
                            output logic [11:0] ta, output logic [63:0] td, output logic f1,
                            output logic c1, output logic d2, output logic busy3);
        @(negedge clk); tlbmiss_i = 1'b0; miss_adr_i = miss; asid_i = asid; ptbr_i = ptbr;
        @(negedge clk); tlbmiss_i = 1'b1;
        cyc_lat = 0;
        do begin @(negedge clk); cyc_lat++; end while (cyc_o !== 1'b1 && cyc_lat < 20);
        adr_seen = adr_o; tlbmiss_i = 1'b0;
        repeat (dly) @(negedge clk);
        ack_i = 1'b1; err_i = err; dat_i = pte;
        @(negedge clk); ack_i = 1'b0; err_i = 1'b0; dat_i = '0;
        wr1 = wrtlb_o; ta = tlbadr_o; td = tlbdat_o; f1 = fault_o; c1 = cyc_o;
        @(negedge clk); d2 = done_o;
        @(negedge clk); busy3 = busy_o;
    endtask

    task automatic do_reset();
        @(negedge clk); rst_i = 1'b1; tlbmiss_i = 1'b0; ack_i = 1'b0; err_i = 1'b0;
        repeat (2) @(negedge clk);
        rst_i = 1'b0;
        ref_way = 0;
    endtask

    task automatic test_reset();
        logic [7:0] ctl;
        repeat (3) @(negedge clk);
        ctl = {cyc_o, stb_o, wrtlb_o, done_o, fault_o, busy_o, 2'b00};
        total++; if (ctl !== 8'h00) begin bad++; $display("FAIL reset_ctl got=%h exp=00", ctl); end
        total++; if (adr_o !== 32'h0) begin bad++; $display("FAIL reset_adr got=%h exp=0", adr_o); end
        total++; if ({tlbadr_o, tlbdat_o} !== 76'h0) begin bad++;
            $display("FAIL reset_tlb got=%h/%h exp=0", tlbadr_o, tlbdat_o); end
        rst_i = 1'b0;
    endtask

    task automatic test_reset_level();
        int seen = 0;
        @(negedge clk); rst_i = 1'b1; tlbmiss_i = 1'b1;
        repeat (3) @(negedge clk);
        rst_i = 1'b0;
        repeat (6) begin @(negedge clk); if (busy_o !== 1'b0 || cyc_o !== 1'b0) seen++; end
        total++; if (seen != 0) begin bad++; $display("FAIL reset_level busy_cycles got=%0d exp=0", seen); end
        tlbmiss_i = 1'b0;
        ref_way = 0;
    endtask

    task automatic test_basic();
        int lat; logic [31:0] a; logic w, f, c, d, b; logic [11:0] ta; logic [63:0] td;
        run_walk(32'h12345678, 8'h05, 32'h0001_0000, 64'h0007_8000_0000_0ABC, 2, 1'b0,
                 lat, a, w, ta, td, f, c, d, b);
        total++; if (lat != 1) begin bad++; $display("FAIL basic_cyc_lat got=%0d exp=1", lat); end
        total++; if (a !== 32'h0003_4688) begin bad++; $display("FAIL basic_adr got=%h exp=00034688", a); end
        total++; if (w !== 1'b1 || c !== 1'b0) begin bad++; $display("FAIL basic_wrtlb got=%b cyc=%b exp=1/0", w, c); end
        total++; if (ta !== 12'h0D1) begin bad++; $display("FAIL basic_tlbadr got=%h exp=0d1", ta); end
        total++; if (td !== 64'h0507_8012_0000_0ABC) begin bad++;
            $display("FAIL basic_tlbdat got=%h exp=0507801200000abc", td); end
        total++; if (d !== 1'b1 || b !== 1'b0) begin bad++; $display("FAIL basic_done got=%b busy=%b exp=1/0", d, b); end
        ref_way++;
    endtask

    task automatic test_invalid_pte();
        int lat, w0; logic [31:0] a; logic w, f, c, d, b; logic [11:0] ta; logic [63:0] td;
        w0 = wr_cnt;
        run_walk(32'h12345678, 8'h05, 32'h0001_0000, 64'h0007_0000_0000_0ABC, 2, 1'b0,
                 lat, a, w, ta, td, f, c, d, b);
        total++; if (f !== 1'b1 || w !== 1'b0 || c !== 1'b0) begin bad++;
            $display("FAIL invalid_fault got f=%b w=%b c=%b exp 1/0/0", f, w, c); end
        total++; if (wr_cnt != w0 || d !== 1'b0) begin bad++;
            $display("FAIL invalid_nowrite writes=%0d done=%b exp 0/0", wr_cnt - w0, d); end
        // Way must not have advanced.
        run_walk(32'h00ABC000, 8'h11, 32'h0, 64'h0000_8000_0000_0001, 0, 1'b0,
                 lat, a, w, ta, td, f, c, d, b);
        total++; if (ta !== m_tadr(ref_way, 32'h00ABC000)) begin bad++;
            $display("FAIL invalid_way got=%h exp=%h", ta, m_tadr(ref_way, 32'h00ABC000)); end
        ref_way++;
    endtask

    task automatic test_round_robin();
        int lat; logic [31:0] a, miss; logic w, f, c, d, b; logic [11:0] ta; logic [63:0] td;
        logic [1:0] exp_way [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            miss = $urandom;
            run_walk(miss, 8'(i), 32'h0020_0000, 64'h0000_8000_0000_1000, 1, 1'b0,
                     lat, a, w, ta, td, f, c, d, b);
            total++; if (ta[11:10] !== exp_way[i] || w !== 1'b1) begin bad++;
                $display("FAIL rr_way%0d got=%0d w=%b exp=%0d", i, ta[11:10], w, exp_way[i]); end
        end
        ref_way = 1;
    endtask

    task automatic test_timeout();
        int n = 0; int w0;
        w0 = wr_cnt;
        @(negedge clk); tlbmiss_i = 1'b0; miss_adr_i = 32'h4000_0000;
        @(negedge clk); tlbmiss_i = 1'b1;
        @(negedge clk); tlbmiss_i = 1'b0;
        while (cyc_o === 1'b1 && n < 400) begin n++; @(negedge clk); end
        total++; if (n != 255) begin bad++; $display("FAIL timeout_len got=%0d exp=255", n); end
        total++; if (fault_o !== 1'b1 || cyc_o !== 1'b0) begin bad++;
            $display("FAIL timeout_fault got f=%b cyc=%b exp 1/0", fault_o, cyc_o); end
        @(negedge clk);
        total++; if (wr_cnt != w0 || busy_o !== 1'b0) begin bad++;
            $display("FAIL timeout_idle writes=%0d busy=%b exp 0/0", wr_cnt - w0, busy_o); end
    endtask

    task automatic test_err_ack();
        int lat, w0; logic [31:0] a; logic w, f, c, d, b; logic [11:0] ta; logic [63:0] td;
        w0 = wr_cnt;
        run_walk(32'h0F0F0000, 8'h22, 32'h0, 64'h0000_8000_0000_0000, 1, 1'b1,
                 lat, a, w, ta, td, f, c, d, b);
        total++; if (f !== 1'b1 || w !== 1'b0 || wr_cnt != w0) begin bad++;
            $display("FAIL err_ack got f=%b w=%b writes=%0d exp 1/0/0", f, w, wr_cnt - w0); end
    endtask

    task automatic test_pending();
        int w0, n, extra; logic [31:0] miss; logic [63:0] pte;
        miss = 32'h8765_4000; pte = 64'h0000_8000_0000_0FFF;
        w0 = wr_cnt;
        @(negedge clk); tlbmiss_i = 1'b0; miss_adr_i = miss; asid_i = 8'h33; ptbr_i = 32'h0100_0000;
        @(negedge clk); tlbmiss_i = 1'b1;
        n = 0; do begin @(negedge clk); n++; end while (cyc_o !== 1'b1 && n < 20);
        tlbmiss_i = 1'b0;
        @(negedge clk); tlbmiss_i = 1'b1;
        @(negedge clk); tlbmiss_i = 1'b0;
        @(negedge clk); tlbmiss_i = 1'b1;
        @(negedge clk); tlbmiss_i = 1'b0; ack_i = 1'b1; dat_i = pte;
        @(negedge clk); ack_i = 1'b0; dat_i = '0;
        total++; if (wrtlb_o !== 1'b1 || tlbadr_o !== m_tadr(ref_way, miss)) begin bad++;
            $display("FAIL pend_w1 got w=%b ta=%h exp 1/%h", wrtlb_o, tlbadr_o, m_tadr(ref_way, miss)); end
        @(negedge clk);
        total++; if (done_o !== 1'b1) begin bad++; $display("FAIL pend_done1 got=%b exp=1", done_o); end
        @(negedge clk);
        total++; if (busy_o !== 1'b0 || cyc_o !== 1'b0) begin bad++;
            $display("FAIL pend_idle got busy=%b cyc=%b exp 0/0", busy_o, cyc_o); end
        @(negedge clk);
        total++; if (cyc_o !== 1'b1 || adr_o !== m_adr(32'h0100_0000, miss)) begin bad++;
            $display("FAIL pend_walk2 got cyc=%b adr=%h exp 1/%h", cyc_o, adr_o, m_adr(32'h0100_0000, miss)); end
        ack_i = 1'b1; dat_i = pte;
        @(negedge clk); ack_i = 1'b0; dat_i = '0;
        total++; if (wrtlb_o !== 1'b1 || tlbadr_o !== m_tadr(ref_way + 1, miss)) begin bad++;
            $display("FAIL pend_w2 got w=%b ta=%h exp 1/%h", wrtlb_o, tlbadr_o, m_tadr(ref_way + 1, miss)); end
        extra = 0;
        repeat (12) begin @(negedge clk); if (cyc_o === 1'b1) extra++; end
        total++; if (extra != 0 || wr_cnt - w0 != 2) begin bad++;
            $display("FAIL pend_merge got extra_cyc=%0d writes=%0d exp 0/2", extra, wr_cnt - w0); end
        ref_way += 2;
    endtask

    task automatic test_reset_in_read();
        int n, w0; logic [7:0] ctl;
        @(negedge clk); tlbmiss_i = 1'b0; miss_adr_i = 32'h1111_0000;
        @(negedge clk); tlbmiss_i = 1'b1;
        n = 0; do begin @(negedge clk); n++; end while (cyc_o !== 1'b1 && n < 20);
        tlbmiss_i = 1'b0; rst_i = 1'b1;
        @(negedge clk); rst_i = 1'b0;
        ctl = {cyc_o, stb_o, wrtlb_o, done_o, fault_o, busy_o, 2'b00};
        total++; if (ctl !== 8'h00 || adr_o !== 32'h0 || tlbdat_o !== 64'h0 || tlbadr_o !== 12'h0) begin bad++;
            $display("FAIL rst_read got ctl=%h adr=%h ta=%h td=%h exp all 0", ctl, adr_o, tlbadr_o, tlbdat_o); end
        w0 = wr_cnt;
        ack_i = 1'b1; dat_i = 64'h0000_8000_0000_0001;
        @(negedge clk); ack_i = 1'b0; dat_i = '0;
        repeat (4) @(negedge clk);
        total++; if (wr_cnt != w0 || busy_o !== 1'b0) begin bad++;
            $display("FAIL rst_late_ack got writes=%0d busy=%b exp 0/0", wr_cnt - w0, busy_o); end
        ref_way = 0;
    endtask

    task automatic test_random();
        int lat, dly; logic [31:0] a, miss, ptbr; logic [7:0] asid; logic [63:0] pte, td;
        logic w, f, c, d, b, ok, er; logic [11:0] ta;
        for (int i = 0; i < 25; i++) begin
            miss = $urandom; ptbr = $urandom; asid = 8'($urandom);
            pte = {$urandom, $urandom};
            pte[47] = ($urandom_range(0, 3) != 0);
            er = ($urandom_range(0, 7) == 0);
            dly = $urandom_range(0, 5);
            ok = pte[47] && !er;
            run_walk(miss, asid, ptbr, pte, dly, er, lat, a, w, ta, td, f, c, d, b);
            total++; if (lat != 1 || a !== m_adr(ptbr, miss)) begin bad++;
                $display("FAIL rnd%0d_bus got lat=%0d adr=%h exp 1/%h", i, lat, a, m_adr(ptbr, miss)); end
            total++; if (w !== ok || f !== !ok || d !== ok) begin bad++;
                $display("FAIL rnd%0d_outcome got w=%b f=%b d=%b exp ok=%b", i, w, f, d, ok); end
            if (ok) begin
                total++; if (ta !== m_tadr(ref_way, miss) || td !== m_dat(asid, miss, pte)) begin bad++;
                    $display("FAIL rnd%0d_entry got %h/%h exp %h/%h", i, ta, td,
                             m_tadr(ref_way, miss), m_dat(asid, miss, pte)); end
                ref_way++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_reset_level();
        test_basic();
        test_invalid_pte();
        test_round_robin();
        test_timeout();
        test_err_ack();
        test_pending();
        test_reset_in_read();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/any1_tlb_walker.md
ANY1_TLB_WALKER -- requirements
Module: any1_tlb_walker

Interface
REQ-001 SHALL have parameter AWID, default 32, meaning the address width.
REQ-002 SHALL have parameter TMO, default 255, meaning the bus-ack timeout in cycles.
REQ-003 SHALL provide ports:
- clk_i  in  1  clock; one clock domain.
- rst_i  in  1  reset; synchronous, active-high.
- tlbmiss_i  in  1  TLB miss flag.
- miss_adr_i  in  AWID  faulting linear address.
- asid_i  in  8  current ASID.
- ptbr_i  in  AWID  page table base (byte address).
- cyc_o  out  1  bus cycle.
- stb_o  out  1  bus strobe.
- adr_o  out  AWID  bus address.
- ack_i  in  1  bus acknowledge.
- err_i  in  1  bus error.
- dat_i  in  64  bus read data.
- wrtlb_o  out  1  TLB write strobe.
- tlbadr_o  out  12  TLB entry address: [11:10] way, [9:0] index.
- tlbdat_o  out  64  TLB entry data.
- busy_o  out  1  walk in progress.
- done_o  out  1  one-cycle pulse: entry written.
- fault_o  out  1  one-cycle pulse: walk failed.

Function
REQ-004 SHALL detect a walk request as tlbmiss_i high in a cycle where it was low the previous cycle.
REQ-005 SHALL latch a request that arrives while busy as pending, and service it on return to IDLE (one pending max; further requests merge).
REQ-006 SHALL implement states IDLE, READ, WRITE, DONE, FAULT.
REQ-007 IDLE -> READ on a request or pending flag; SHALL latch miss_adr_i and asid_i on that transition.
REQ-008 In READ, SHALL drive cyc_o=stb_o=1 and adr_o = ptbr_i + {miss_adr[AWID-1:14], 3'b000}, truncated to AWID bits with wrap and no carry out.
REQ-009 READ -> WRITE when ack_i=1 and dat_i[47]=1 (PTE valid). SHALL latch dat_i and drop cyc_o/stb_o in the next cycle.
REQ-010 READ -> FAULT when ack_i=1 and dat_i[47]=0, when err_i=1, or when TMO cycles elapse in READ without ack. err_i SHALL take priority over ack_i.
REQ-011 WRITE SHALL be one cycle with wrtlb_o=1 and tlbadr_o = {way, miss_adr[23:14]}.
REQ-012 WRITE SHALL drive tlbdat_o as follows:
- [63:56] = asid
- [55] = pte[55]
- [54:53] = 0 (dirty and accessed cleared)
- [52:40] = pte[52:40]
- [39:32] = miss_adr[AWID-1:24] (AWID=32)
- [31:0] = pte[31:0]
REQ-013 way SHALL be a 2-bit round-robin counter that increments by 1 after each WRITE and wraps from 3 to 0.
REQ-014 WRITE -> DONE; DONE SHALL assert done_o for one cycle, then go to IDLE.
REQ-015 FAULT SHALL assert fault_o for one cycle and then go to IDLE, with no TLB write.
REQ-016 busy_o SHALL be 1 in all states except IDLE.
REQ-017 Total latency SHALL be: request edge at cycle N -> cyc_o at N+1; ack at cycle M -> wrtlb_o at M+1 -> done_o at M+2.
REQ-018 The timeout counter SHALL clear on entry to READ.

Reset
REQ-019 When rst_i=1 at a clock edge, state SHALL become IDLE with cyc_o, stb_o, wrtlb_o, done_o, fault_o, busy_o and the pending flag all 0; way=0; adr_o, tlbadr_o and tlbdat_o all 0.
REQ-020 Reset in mid-walk SHALL abandon the bus cycle in the same edge, and a later ack_i SHALL be ignored.
REQ-021 A tlbmiss_i level that is high throughout reset SHALL NOT count as an edge after reset.

Verification
REQ-022 Basic walk: ptbr=0x00010000, miss_adr=0x12345678, asid=0x05, PTE=0x0007_8000_0000_0ABC with ack 2 cycles after stb -> adr_o=0x00034688, then tlbadr_o=0x0D1, tlbdat_o=0x0507_8012_0000_0ABC, then done_o.
REQ-023 Invalid PTE: same stimulus with PTE bit 47=0 -> fault_o pulse, wrtlb_o never asserted, way unchanged.
REQ-024 Round-robin: four successful walks -> tlbadr_o[11:10] = 0,1,2,3; a fifth walk -> 0.
REQ-025 Timeout and error: no ack for 255 cycles -> fault_o and cyc_o=0; err_i with ack_i in the same cycle -> fault_o, no write.
REQ-026 Pending: a second miss edge during READ -> after done_o, a second walk starts in the next IDLE cycle; a third edge during the same walk adds no third walk.
REQ-027 Reset in READ: rst_i while cyc_o=1 -> all outputs 0 the next cycle; a later ack_i causes no write.
